// File: rtl/uart_ctrl.sv
// Buffered sequencing controller for the uart core: TX/RX FIFOs, transmit
// strobe FSM, receive error/overflow bookkeeping and core reset generation.
module uart_ctrl #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             flush,
  input  logic             err_clr,
  output logic             rx_overflow,
  output logic [7:0]       err_cnt,
  output logic [TX_AW:0]   tx_level,
  output logic [RX_AW:0]   rx_level,
  output logic             busy,
  output logic             uart_rst,
  output logic             uart_transmit,
  output logic [7:0]       uart_tx_byte,
  input  logic             uart_is_transmitting,
  input  logic             uart_received,
  input  logic [7:0]       uart_rx_byte,
  input  logic             uart_recv_error
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_ONE = 1;
  localparam logic [RX_AW:0] RX_ONE = 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;

  // ---------------- core reset: 2-flop sync on rst_n, stretched by flush
  logic sync_reg, flush_d_reg, uart_rst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= 1'b0;
      flush_d_reg  <= 1'b0;
      uart_rst_reg <= 1'b1;
    end else begin
      sync_reg     <= 1'b1;
      flush_d_reg  <= flush;
      uart_rst_reg <= ~sync_reg | flush | flush_d_reg;
    end
  end

  assign uart_rst = uart_rst_reg;

  // ---------------- TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
  assign tx_full  = (tx_wr_ptr_reg[TX_AW] != tx_rd_ptr_reg[TX_AW]) &&
                    (tx_wr_ptr_reg[TX_AW-1:0] == tx_rd_ptr_reg[TX_AW-1:0]);
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & ~tx_full & ~flush;
  assign tx_level = tx_wr_ptr_reg - tx_rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[TX_AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
    end else if (flush) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_ONE;
    end
  end

  // ---------------- TX FSM
  tx_state_t  state_reg, state_next;
  logic       transmit_reg, transmit_next;
  logic [7:0] tx_byte_reg, tx_byte_next;
  logic [2:0] wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      transmit_reg <= 1'b0;
      tx_byte_reg  <= 8'd0;
      wait_cnt_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      transmit_reg <= transmit_next;
      tx_byte_reg  <= tx_byte_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    transmit_next = 1'b0;
    tx_byte_next  = tx_byte_reg;
    wait_cnt_next = wait_cnt_reg;
    tx_pop        = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!tx_empty && !uart_is_transmitting && !uart_rst_reg) begin
            tx_byte_next  = tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];
            transmit_next = 1'b1;
            tx_pop        = 1'b1;
            state_next    = START;
          end
        end
        START: begin
          wait_cnt_next = 3'd0;
          state_next    = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // a core that never acknowledges costs us the byte, not a hang
          if (uart_is_transmitting)    state_next = WAIT_DONE;
          else if (wait_cnt_reg == 3'd7) state_next = IDLE;
          else                         wait_cnt_next = wait_cnt_reg + 3'd1;
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign uart_transmit = transmit_reg;
  assign uart_tx_byte  = tx_byte_reg;
  assign busy          = (state_reg != IDLE) | ~tx_empty;

  // ---------------- RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic           rx_empty, rx_full, rx_read, rx_push, rx_drop;

  assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
  assign rx_full  = (rx_wr_ptr_reg[RX_AW] != rx_rd_ptr_reg[RX_AW]) &&
                    (rx_wr_ptr_reg[RX_AW-1:0] == rx_rd_ptr_reg[RX_AW-1:0]);
  assign rx_valid = ~rx_empty;
  assign rx_data  = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];
  assign rx_level = rx_wr_ptr_reg - rx_rd_ptr_reg;
  assign rx_read  = rx_valid & rx_ready & ~flush;
  // a simultaneous read frees the slot the push lands in
  assign rx_push  = uart_received & ~flush & (~rx_full | rx_read);
  assign rx_drop  = uart_received & ~flush & rx_full & ~rx_read;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= uart_rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else if (flush) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_ONE;
      if (rx_read) rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_ONE;
    end
  end

  // ---------------- error bookkeeping
  logic [7:0] err_cnt_reg;
  logic       overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg  <= 8'd0;
      overflow_reg <= 1'b0;
    end else begin
      if (err_clr)
        err_cnt_reg <= {7'd0, uart_recv_error};
      else if (uart_recv_error && err_cnt_reg != 8'hFF)
        err_cnt_reg <= err_cnt_reg + 8'd1;
      if (rx_drop)      overflow_reg <= 1'b1;
      else if (err_clr) overflow_reg <= 1'b0;
    end
  end

  assign err_cnt     = err_cnt_reg;
  assign rx_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: vector table for the RX/error path plus
// directed sequences against a small behavioural model of the uart core.
module tb_uart_ctrl;
  localparam int TX_AW = 4;
  localparam int RX_AW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             flush;
  logic             err_clr;
  logic             rx_overflow;
  logic [7:0]       err_cnt;
  logic [TX_AW:0]   tx_level;
  logic [RX_AW:0]   rx_level;
  logic             busy;
  logic             uart_rst;
  logic             uart_transmit;
  logic [7:0]       uart_tx_byte;
  logic             uart_is_transmitting;
  logic             uart_received;
  logic [7:0]       uart_rx_byte;
  logic             uart_recv_error;

  always #5 clk = ~clk;

  uart_ctrl #(.TX_AW(TX_AW), .RX_AW(RX_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .flush(flush), .err_clr(err_clr), .rx_overflow(rx_overflow),
    .err_cnt(err_cnt), .tx_level(tx_level), .rx_level(rx_level),
    .busy(busy), .uart_rst(uart_rst), .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte), .uart_is_transmitting(uart_is_transmitting),
    .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
    .uart_recv_error(uart_recv_error)
  );

  // core model: samples the strobe, then stays busy for core_len cycles
  int         core_cnt = 0;
  int         core_len = 160;
  logic       core_hold = 1'b0;
  int         pulses = 0;
  int         overlap = 0;
  int         wide = 0;
  logic       prev_tx = 1'b0;
  logic [7:0] tx_log [$];

  assign uart_is_transmitting = core_hold | (core_cnt != 0);

  always @(posedge clk) begin
    prev_tx <= uart_transmit;
    if (uart_transmit) begin
      tx_log.push_back(uart_tx_byte);
      pulses <= pulses + 1;
      if (core_hold || core_cnt != 0) overlap <= overlap + 1;
      if (prev_tx) wide <= wide + 1;
    end
    if (uart_rst)                               core_cnt <= 0;
    else if (core_cnt != 0)                     core_cnt <= core_cnt - 1;
    else if (uart_transmit && !core_hold)       core_cnt <= core_len;
  end

  int total_checks = 0;
  int passed_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed_checks++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       recv;
    logic [7:0] rbyte;
    logic       err;
    logic       rd;
    logic       clr;
    int         lvl;
    logic       vld;
    logic [7:0] data;
    logic       ovf;
    logic [7:0] errc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int         n;
    int         p0;
    logic [7:0] e;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h11, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h11, 1'b0, 8'd1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h22, 1'b0, 8'd1};
    vecs[3] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h33, 1'b0, 8'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h33, 1'b0, 8'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h33, 1'b0, 8'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'd1};
    vecs[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h44, 1'b0, 8'd2};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 8'd0};

    rst_n = 1'b0; tx_data = 8'd0; tx_valid = 1'b0; rx_ready = 1'b0;
    flush = 1'b0; err_clr = 1'b0; uart_received = 1'b0;
    uart_rx_byte = 8'd0; uart_recv_error = 1'b0;

    // ---- reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_rst", uart_rst, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_tx_byte", uart_tx_byte, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_overflow", rx_overflow, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_edge1", uart_rst, 1);
    tick();
    chk("rst_release_edge2", uart_rst, 0);
    $display("reset released, uart_rst=%0d", uart_rst);

    // ---- RX / error vector table
    for (int i = 0; i < 9; i++) begin
      uart_received = vecs[i].recv; uart_rx_byte = vecs[i].rbyte;
      uart_recv_error = vecs[i].err; rx_ready = vecs[i].rd; err_clr = vecs[i].clr;
      tick();
      uart_received = 1'b0; uart_recv_error = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      chk("vec_rx_level", rx_level, vecs[i].lvl);
      chk("vec_rx_valid", rx_valid, vecs[i].vld);
      if (vecs[i].vld) chk("vec_rx_data", rx_data, vecs[i].data);
      chk("vec_overflow", rx_overflow, vecs[i].ovf);
      chk("vec_err_cnt", err_cnt, vecs[i].errc);
      $display("vec %0d: recv=%0d err=%0d rd=%0d clr=%0d -> lvl=%0d data=0x%0h err_cnt=%0d",
               i, vecs[i].recv, vecs[i].err, vecs[i].rd, vecs[i].clr, rx_level, rx_data, err_cnt);
    end

    // ---- RX overflow
    for (int i = 0; i < 17; i++) begin
      uart_received = 1'b1; uart_rx_byte = 8'(8'h80 + i);
      tick();
    end
    uart_received = 1'b0;
    chk("ovf_level", rx_level, 16);
    chk("ovf_flag", rx_overflow, 1);
    chk("ovf_head", rx_data, 8'h80);
    uart_received = 1'b1; uart_rx_byte = 8'hC0; rx_ready = 1'b1;
    tick();
    uart_received = 1'b0; rx_ready = 1'b0;
    chk("ovf_pop_push_level", rx_level, 16);
    chk("ovf_pop_push_head", rx_data, 8'h81);
    uart_received = 1'b1; uart_rx_byte = 8'hC1; err_clr = 1'b1;
    tick();
    uart_received = 1'b0; err_clr = 1'b0;
    chk("ovf_clr_with_drop", rx_overflow, 1);
    chk("ovf_clr_with_drop_level", rx_level, 16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr_alone", rx_overflow, 0);
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 8'(8'h81 + i) : 8'hC0;
      chk("ovf_drain_data", rx_data, e);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("ovf_drain_level", rx_level, 0);
    chk("ovf_drain_valid", rx_valid, 0);
    $display("rx overflow sequence done, level=%0d", rx_level);

    // ---- error saturation
    uart_recv_error = 1'b1;
    repeat (300) tick();
    uart_recv_error = 1'b0;
    chk("err_saturate", err_cnt, 255);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr_alone", err_cnt, 0);
    err_clr = 1'b1; uart_recv_error = 1'b1; tick();
    err_clr = 1'b0; uart_recv_error = 1'b0;
    chk("err_clr_with_err", err_cnt, 1);
    $display("error saturation done, err_cnt=%0d", err_cnt);

    // ---- single byte
    core_len = 160;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("single_level_after_write", tx_level, 1);
    chk("single_no_strobe_yet", uart_transmit, 0);
    chk("single_busy", busy, 1);
    tick();
    chk("single_strobe", uart_transmit, 1);
    chk("single_byte", uart_tx_byte, 8'hA5);
    chk("single_popped", tx_level, 0);
    tick();
    chk("single_strobe_one_cycle", uart_transmit, 0);
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk("single_busy_fall_cycles", n, 161);
    chk("single_pulses", pulses, 1);
    chk("single_log_size", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("single_log_byte", tx_log[0], 8'hA5);
    tx_log.delete();
    $display("single byte sent after %0d busy cycles", n);

    // ---- TX fill with stalled core, then release
    core_hold = 1'b1; core_len = 20;
    p0 = pulses;
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      chk("fill_ready", tx_ready, (i < 16) ? 1 : 0);
      tick();
    end
    tx_valid = 1'b0;
    chk("fill_level", tx_level, 16);
    chk("fill_not_ready", tx_ready, 0);
    chk("fill_no_strobe", pulses, p0);
    core_hold = 1'b0;
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk("fill_drain_timeout", busy, 0);
    chk("fill_sent_count", tx_log.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < tx_log.size()) chk("fill_order", tx_log[i], i);
    chk("fill_overlap", overlap, 0);
    chk("fill_wide_strobe", wide, 0);
    $display("tx fill drained %0d bytes in %0d cycles", tx_log.size(), n);
    tx_log.delete();

    // ---- flush mid-frame
    core_len = 160;
    uart_received = 1'b1; uart_rx_byte = 8'h5A; tick();
    uart_rx_byte = 8'h5B; tick();
    uart_received = 1'b0;
    chk("flush_rx_pre_level", rx_level, 2);
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'(8'h50 + i); tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    repeat (5) tick();
    chk("flush_pre_level", tx_level, 5);
    chk("flush_core_busy", uart_is_transmitting, 1);
    p0 = pulses;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_tx_level", tx_level, 0);
    chk("flush_rx_level", rx_level, 0);
    chk("flush_rx_valid", rx_valid, 0);
    chk("flush_uart_rst1", uart_rst, 1);
    chk("flush_transmit", uart_transmit, 0);
    chk("flush_busy", busy, 0);
    chk("flush_err_kept", err_cnt, 1);
    chk("flush_tx_ready", tx_ready, 1);
    tick();
    chk("flush_uart_rst2", uart_rst, 1);
    tick();
    chk("flush_uart_rst_end", uart_rst, 0);
    repeat (50) tick();
    chk("flush_no_more_strobes", pulses, p0);
    chk("flush_still_idle", busy, 0);
    $display("flush done, tx_level=%0d rx_level=%0d", tx_level, rx_level);

    // ---- asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'(8'h77 + i); tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    repeat (6) tick();
    chk("arst_pre_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx_level", tx_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_uart_rst", uart_rst, 1);
    chk("arst_transmit", uart_transmit, 0);
    chk("arst_tx_byte", uart_tx_byte, 0);
    chk("arst_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_release", uart_rst, 0);
    $display("async reset mid-frame done");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
